// File: rtl/sdram_ctrl_pkg.sv
// Shared types for the SDRAM request path: default widths, request-queue FSM
// states and the default-width request record.
package sdram_ctrl_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_MASK_W = SDRAM_DATA_W / 8;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } req_state_t;

  typedef struct packed {
    logic                    wr;
    logic [SDRAM_ADDR_W-1:0] addr;
    logic [SDRAM_DATA_W-1:0] data;
    logic [SDRAM_MASK_W-1:0] mask;
  } sdram_req_t;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == STAT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous FIFO with wrap-bit pointers, occupancy level, registered read
// port, a registered not-full flag and a peek at the head entry's top bit.
module sdram_req_fifo #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     head_msb,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] FULL_LEVEL = {1'b1, {PTR_W{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   level_next;
  logic [WIDTH-1:0] head;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && ready;
  assign do_pop   = pop && (level != '0);
  assign head     = mem[rd_ptr[PTR_W-1:0]];
  assign head_msb = head[WIDTH-1];

  always_comb begin
    level_next = level;
    case ({do_push, do_pop})
      2'b10:   level_next = level + LVL_ONE;
      2'b01:   level_next = level - LVL_ONE;
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  // ready is a flop so a pop in the same cycle never opens the door to a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ready    <= 1'b0;
      pop_data <= '0;
    end else begin
      level <= level_next;
      ready <= (level_next != FULL_LEVEL);
      if (do_push) begin
        wr_ptr <= wr_ptr + LVL_ONE;
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + LVL_ONE;
        pop_data <= head;
      end
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Request FIFO in front of sdram_controller: issues one access at a time and
// returns read data in order. Define SDRAM_REQ_QUEUE_STATS_EN for issue counters.
module sdram_req_queue
  import sdram_ctrl_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = SDRAM_ADDR_W,
  parameter int DATA_WIDTH = SDRAM_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset_n_port,
  input  logic                      req_valid_port,
  output logic                      req_ready_port,
  input  logic                      req_wr_port,
  input  logic [ADDR_WIDTH-1:0]     req_addr_port,
  input  logic [DATA_WIDTH-1:0]     req_wr_data_port,
  input  logic [DATA_WIDTH/8-1:0]   req_wr_mask_port,
  output logic                      rsp_valid_port,
  output logic [DATA_WIDTH-1:0]     rsp_rd_data_port,
  output logic [$clog2(DEPTH):0]    level_port,
  output logic [15:0]               rd_count_port,
  output logic [15:0]               wr_count_port,
  input  logic                      ctrl_busy_port,
  input  logic                      ctrl_ready_port,
  input  logic [DATA_WIDTH-1:0]     ctrl_rd_data_port,
  output logic [ADDR_WIDTH-1:0]     ctrl_addr_port,
  output logic [DATA_WIDTH-1:0]     ctrl_wr_data_port,
  output logic [DATA_WIDTH/8-1:0]   ctrl_wr_mask_port,
  output logic                      ctrl_wr_en_port,
  output logic                      ctrl_rd_en_port
);

  localparam int MASK_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [MASK_W-1:0]     mask;
  } req_t;

  req_t       push_req;
  req_t       issue;
  logic       head_wr;
  logic       push;
  logic       pop;
  req_state_t state;
  logic       retry_cnt;
  logic       rd_pending;

  assign push_req = '{wr:   req_wr_port,
                      addr: req_addr_port,
                      data: req_wr_data_port,
                      mask: req_wr_mask_port};

  assign push = req_valid_port && req_ready_port;
  assign pop  = (state == ST_IDLE) && (level_port != '0) && !ctrl_busy_port;

  // The FIFO's registered read port doubles as the issue register.
  sdram_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n_port),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (issue),
    .head_msb  (head_wr),
    .level     (level_port),
    .ready     (req_ready_port)
  );

  assign ctrl_addr_port    = issue.addr;
  assign ctrl_wr_data_port = issue.data;
  assign ctrl_wr_mask_port = issue.mask;

  // A pulse with no busy within two cycles was lost to a refresh; re-pulse it.
  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      state            <= ST_IDLE;
      retry_cnt        <= 1'b0;
      rd_pending       <= 1'b0;
      ctrl_wr_en_port  <= 1'b0;
      ctrl_rd_en_port  <= 1'b0;
      rsp_valid_port   <= 1'b0;
      rsp_rd_data_port <= '0;
    end else begin
      ctrl_wr_en_port <= 1'b0;
      ctrl_rd_en_port <= 1'b0;
      rsp_valid_port  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state           <= ST_ISSUE;
            ctrl_wr_en_port <= head_wr;
            ctrl_rd_en_port <= !head_wr;
            rd_pending      <= !head_wr;
          end
        end
        ST_ISSUE: begin
          state     <= ST_WAIT_BUSY;
          retry_cnt <= 1'b0;
        end
        ST_WAIT_BUSY: begin
          if (ctrl_busy_port) begin
            state <= ST_WAIT_DONE;
          end else if (retry_cnt) begin
            state           <= ST_ISSUE;
            ctrl_wr_en_port <= issue.wr;
            ctrl_rd_en_port <= !issue.wr;
          end else begin
            retry_cnt <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!ctrl_busy_port) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (rd_pending && ctrl_ready_port &&
          (state == ST_WAIT_BUSY || state == ST_WAIT_DONE)) begin
        rsp_rd_data_port <= ctrl_rd_data_port;
        rsp_valid_port   <= 1'b1;
        rd_pending       <= 1'b0;
      end
    end
  end

`ifdef SDRAM_REQ_QUEUE_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  // An access is counted once, when the controller first shows busy for it.
  always_ff @(posedge clk or negedge reset_n_port) begin
    if (!reset_n_port) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == ST_WAIT_BUSY && ctrl_busy_port) begin
      if (issue.wr) begin
        wr_cnt <= sat_inc16(wr_cnt);
      end else begin
        rd_cnt <= sat_inc16(rd_cnt);
      end
    end
  end

  assign rd_count_port = rd_cnt;
  assign wr_count_port = wr_cnt;
`else
  assign rd_count_port = '0;
  assign wr_count_port = '0;
`endif

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue with a small behavioural controller model
// (3-cycle busy, ready on the last busy cycle, optional ignored pulses).
module tb_sdram_req_queue;
  import sdram_ctrl_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 23;
  localparam int DW    = 32;
  localparam int MW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          m_rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wr_data;
  logic [MW-1:0] req_wr_mask;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rd_data;
  logic [3:0]    level;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
  logic          ctrl_busy;
  logic          ctrl_ready;
  logic [DW-1:0] ctrl_rd_data;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wr_data;
  logic [MW-1:0] ctrl_wr_mask;
  logic          ctrl_wr_en;
  logic          ctrl_rd_en;

  sdram_req_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .reset_n_port      (reset_n),
    .req_valid_port    (req_valid),
    .req_ready_port    (req_ready),
    .req_wr_port       (req_wr),
    .req_addr_port     (req_addr),
    .req_wr_data_port  (req_wr_data),
    .req_wr_mask_port  (req_wr_mask),
    .rsp_valid_port    (rsp_valid),
    .rsp_rd_data_port  (rsp_rd_data),
    .level_port        (level),
    .rd_count_port     (rd_count),
    .wr_count_port     (wr_count),
    .ctrl_busy_port    (ctrl_busy),
    .ctrl_ready_port   (ctrl_ready),
    .ctrl_rd_data_port (ctrl_rd_data),
    .ctrl_addr_port    (ctrl_addr),
    .ctrl_wr_data_port (ctrl_wr_data),
    .ctrl_wr_mask_port (ctrl_wr_mask),
    .ctrl_wr_en_port   (ctrl_wr_en),
    .ctrl_rd_en_port   (ctrl_rd_en)
  );

  // Controller model
  logic          m_busy;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  int            m_cnt;
  logic          m_is_rd;
  logic [AW-1:0] m_addr;
  bit            hold_busy = 1'b0;
  int            ign_req = 0;
  int            ign_seen;
  int            pulse_cnt;
  sdram_req_t    acc_log[$];
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  assign ctrl_busy    = m_busy | hold_busy;
  assign ctrl_ready   = m_ready;
  assign ctrl_rd_data = m_rdata;

  always @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      m_busy    <= 1'b0;
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      m_cnt     <= 0;
      m_is_rd   <= 1'b0;
      m_addr    <= '0;
      ign_seen  <= 0;
      pulse_cnt <= 0;
    end else begin
      m_ready <= 1'b0;
      if (ctrl_wr_en || ctrl_rd_en) pulse_cnt <= pulse_cnt + 1;
      if (m_busy) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 2 && m_is_rd) begin
          m_ready <= 1'b1;
          m_rdata <= mem_model.exists(m_addr) ? mem_model[m_addr] : '0;
        end
        if (m_cnt == 1) m_busy <= 1'b0;
      end else if (!hold_busy && (ctrl_wr_en || ctrl_rd_en)) begin
        if (ign_seen < ign_req) begin
          ign_seen <= ign_seen + 1;
        end else begin
          m_busy  <= 1'b1;
          m_cnt   <= 3;
          m_is_rd <= ctrl_rd_en;
          m_addr  <= ctrl_addr;
          acc_log.push_back('{wr: ctrl_wr_en, addr: ctrl_addr,
                              data: ctrl_wr_data, mask: ctrl_wr_mask});
          if (ctrl_wr_en) mem_model[ctrl_addr] = ctrl_wr_data;
        end
      end
    end
  end

  int rsp_cnt = 0;
  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic          exp_rsp;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitPulse(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ctrl_wr_en || ctrl_rd_en) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pushOne(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [MW-1:0] mask);
    @(negedge clk);
    req_valid   = 1'b1;
    req_wr      = wr;
    req_addr    = addr;
    req_wr_data = data;
    req_wr_mask = mask;
    checkOutput("push_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    int r0;
    pushOne(v.wr, v.addr, v.data, v.mask);
    r0 = rsp_cnt;
    waitPulse(lat);
    checkOutput("issue_latency", lat, 2);
    checkOutput("wr_en", ctrl_wr_en, v.wr);
    checkOutput("rd_en", ctrl_rd_en, !v.wr);
    checkOutput("ctrl_addr", ctrl_addr, v.addr);
    checkOutput("ctrl_wr_data", ctrl_wr_data, v.data);
    checkOutput("ctrl_wr_mask", ctrl_wr_mask, v.mask);
    repeat (8) @(negedge clk);
    checkOutput("rsp_strobes", rsp_cnt - r0, v.exp_rsp ? 1 : 0);
    if (v.exp_rsp) checkOutput("rsp_data", rsp_rd_data, v.exp_rd);
  endtask

  initial begin
    int lat;
    int p0;
    int a0;
    int r0;
    int w0;
    int accepted;

    vecs[0] = '{1'b1, 23'h000010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 23'h7FFFFF, 32'h12345678, 4'hF, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 23'h7FFFFF, 32'h0,        4'h0, 1'b1, 32'h12345678};
    vecs[3] = '{1'b0, 23'h000010, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 23'h000020, 32'hCAFEF00D, 4'h3, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 23'h000020, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 23'h000000, 32'hA5A5A5A5, 4'h5, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 23'h000000, 32'h0,        4'h0, 1'b1, 32'hA5A5A5A5};

    reset_n = 1'b0;
    m_rst_n = 1'b0;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wr_data = '0;
    req_wr_mask = '0;

    #1;
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_wr_en", ctrl_wr_en, 0);
    checkOutput("rst_rd_en", ctrl_rd_en, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", req_ready, 0);
    @(negedge clk);
    checkOutput("ready_after_edge", req_ready, 1);

    $display("[TB] table-driven transactions");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] refresh collision re-pulse");
    p0 = pulse_cnt;
    a0 = acc_log.size();
    w0 = wr_count;
    ign_req = ign_seen + 1;
    pushOne(1'b1, 23'h000400, 32'h0BADF00D, 4'hF);
    waitPulse(lat);
    checkOutput("refresh_first_latency", lat, 2);
    waitPulse(lat);
    checkOutput("refresh_repulse_gap", lat, 3);
    repeat (8) @(negedge clk);
    checkOutput("refresh_pulses", pulse_cnt - p0, 2);
    checkOutput("refresh_accesses", acc_log.size() - a0, 1);
    checkOutput("refresh_addr", acc_log[acc_log.size() - 1].addr, 23'h000400);
`ifdef SDRAM_REQ_QUEUE_STATS_EN
    checkOutput("refresh_wr_count", wr_count - w0, 1);
`else
    checkOutput("refresh_wr_count", wr_count - w0, 0);
`endif

    $display("[TB] fill with busy held, then push against pop at full");
    a0 = acc_log.size();
    accepted = 0;
    @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid   = 1'b1;
      req_wr      = 1'b1;
      req_addr    = 23'h000100 + 23'(i);
      req_wr_data = 32'hA0000000 + 32'(i);
      req_wr_mask = 4'hF;
      if (req_ready) accepted++;
    end
    checkOutput("fill_accepted", accepted, 8);
    checkOutput("fill_level", level, 8);
    checkOutput("fill_ready", req_ready, 0);
    hold_busy = 1'b0;
    @(negedge clk);
    checkOutput("simul_level", level, 7);
    req_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if ((acc_log.size() - a0 >= 8) && level == 0 && !ctrl_busy) break;
    end
    repeat (6) @(negedge clk);
    checkOutput("drain_count", acc_log.size() - a0, 8);
    for (int i = 0; i < 8; i++) begin
      if (a0 + i < acc_log.size()) begin
        checkOutput("drain_addr", acc_log[a0 + i].addr, 23'h000100 + 23'(i));
        checkOutput("drain_data", acc_log[a0 + i].data, 32'hA0000000 + 32'(i));
      end
    end
    checkOutput("drain_level", level, 0);

    $display("[TB] reset during read wait");
    r0 = rsp_cnt;
    pushOne(1'b0, 23'h7FFFFF, 32'h0, 4'h0);
    waitPulse(lat);
    checkOutput("rstrd_latency", lat, 2);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("rstrd_ready", req_ready, 0);
    checkOutput("rstrd_level", level, 0);
    checkOutput("rstrd_rsp_valid", rsp_valid, 0);
    checkOutput("rstrd_rsp_data", rsp_rd_data, 0);
    checkOutput("rstrd_addr", ctrl_addr, 0);
    checkOutput("rstrd_wr_data", ctrl_wr_data, 0);
    checkOutput("rstrd_mask", ctrl_wr_mask, 0);
    checkOutput("rstrd_wr_en", ctrl_wr_en, 0);
    checkOutput("rstrd_rd_en", ctrl_rd_en, 0);
    checkOutput("rstrd_rd_count", rd_count, 0);
    checkOutput("rstrd_wr_count", wr_count, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rstrd_no_rsp", rsp_cnt - r0, 0);
    checkOutput("rstrd_level_after", level, 0);
    checkOutput("rstrd_ready_after", req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_req_queue.md
# sdram_req_queue

Request queue sitting directly upstream of `sdram_controller`, between the SoC bus and the controller's `soc_side_*` interface. Buffers read/write requests from a valid/ready master in a FIFO, issues them one at a time to the controller while respecting its `busy`/`ready` handshake, and returns read data in request order with a one-cycle `rsp_valid` strobe. Lets the SoC post writes and queue reads without stalling on refresh or on activate/precharge latency.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `ADDR_WIDTH`, 23: word address width (8M x 32-bit).
- `DATA_WIDTH`, 32: data width; mask width is `DATA_WIDTH/8`.
- `clk` in 1: single clock, same as controller.
- `reset_n_port` in 1: asynchronous, active-low reset.
- `req_valid_port` in 1: request present.
- `req_ready_port` out 1: queue accepts request this cycle.
- `req_wr_port` in 1: 1 = write, 0 = read.
- `req_addr_port` in ADDR_WIDTH: word address.
- `req_wr_data_port` in DATA_WIDTH: write data.
- `req_wr_mask_port` in DATA_WIDTH/8: byte mask, passed to controller unchanged.
- `rsp_valid_port` out 1: one-cycle strobe, read data valid.
- `rsp_rd_data_port` out DATA_WIDTH: read data, held until next strobe.
- `level_port` out $clog2(DEPTH)+1: FIFO occupancy.
- `rd_count_port`, `wr_count_port` out 16 each: issue counters (see Configuration).
- `ctrl_busy_port` in 1, `ctrl_ready_port` in 1, `ctrl_rd_data_port` in DATA_WIDTH: from controller.
- `ctrl_addr_port` out ADDR_WIDTH, `ctrl_wr_data_port` out DATA_WIDTH, `ctrl_wr_mask_port` out DATA_WIDTH/8, `ctrl_wr_en_port` out 1, `ctrl_rd_en_port` out 1: to controller.

## Operation
- Accept: `req_ready_port = (level < DEPTH)`, registered-state derived, no dependence on pop in same cycle. Push when `req_valid_port & req_ready_port`.
- Controller contract: samples `wr_en`/`rd_en` when `busy` low; raises `busy` within 2 cycles; drops `busy` on completion; for reads pulses `ready` for one cycle with `rd_data` valid, on or before the cycle `busy` falls.
- FSM, one outstanding access:
  - IDLE: FIFO non-empty and `ctrl_busy_port` low -> pop head into issue register, go ISSUE.
  - ISSUE: drive `ctrl_wr_en_port` or `ctrl_rd_en_port` high exactly one cycle with address/data/mask from issue register -> WAIT_BUSY.
  - WAIT_BUSY: wait `ctrl_busy_port` high -> WAIT_DONE. If 2 cycles pass without busy, return to ISSUE and re-pulse (covers refresh collision).
  - WAIT_DONE: `ctrl_busy_port` low -> IDLE. For reads, `ctrl_ready_port` captures `ctrl_rd_data_port` into `rsp_rd_data_port` and pulses `rsp_valid_port` next cycle.
- `ctrl_ready_port` outside a pending read is ignored.
- Push and pop in same cycle: level unchanged; full with simultaneous pop still refuses push.
- Address/data/mask outputs hold last issued values between accesses.
- Reset: FIFO empty, FSM IDLE, all outputs 0 (`req_ready_port` becomes 1 the first cycle after release); in-flight access dropped, no `rsp_valid_port`.

## Timing
- Push at cycle N into empty queue, controller idle: pop N+1, enable pulse N+2.
- Read response: `rsp_valid_port` one cycle after `ctrl_ready_port`.
- Back-to-back: next enable no earlier than 2 cycles after `busy` falls.
- All outputs registered.

## Configuration
- `SDRAM_REQ_QUEUE_STATS_EN` defined: `rd_count_port`/`wr_count_port` count enable pulses accepted (busy seen), saturating at 16'hFFFF, cleared by reset; re-pulses counted once.
- Undefined: both ports tied to 0, no counter logic.

## Structure
- `sdram_ctrl_pkg`: ADDR/DATA width defaults, FSM state enum, request struct (wr, addr, data, mask).
- Sub-module `sdram_req_fifo`: synchronous FIFO with pointer wrap, level output, registered read.

## Test plan
- Single write addr 23'h000010, data 32'hDEADBEEF, mask 4'hF -> one `ctrl_wr_en_port` pulse 2 cycles after push with matching outputs; no `rsp_valid_port`.
- Write 32'h12345678 to 23'h7FFFFF then read it with controller model -> `rsp_valid_port` once, data 32'h12345678.
- Push 9 requests with DEPTH=8, controller held busy -> `req_ready_port` low after 8th, `level_port`=8; release busy -> all 8 issued in order.
- Enable pulse lands while model holds busy low 3 cycles (refresh) -> re-pulse, single access executed; counters increment by 1 with STATS_EN.
- Reset asserted during WAIT_DONE of a read -> no `rsp_valid_port`, `level_port`=0, all outputs 0.
- Simultaneous push and pop at level 8 -> push refused, level 7 next cycle.
